// File: rtl/cache_data.sv
//==============================================================================
// Module      : cache_data
// Description : Direct-mapped write-back data cache with byte-masked stores,
//               per-line dirty bits and burst fill/write-back to BurstRAM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cache_data #(
    parameter int LINE_IX_BITWIDTH         = 1,
    parameter int ADDRESS_BITWIDTH         = 32,
    parameter int DATA_BITWIDTH            = 32,
    parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
    parameter int RAM_DEPTH_BITWIDTH       = 4,
    parameter int RAM_BURST_DATA_BITWIDTH  = 64,
    parameter int RAM_BURST_DATA_COUNT     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [ADDRESS_BITWIDTH-1:0]          address,
    input  logic [DATA_BITWIDTH/8-1:0]           write_enable,
    input  logic [DATA_BITWIDTH-1:0]             data_in,
    output logic [DATA_BITWIDTH-1:0]             data_out,
    output logic                                 data_ready,
    output logic                                 busy,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);

    localparam int c_data_bytes     = DATA_BITWIDTH / 8;
    localparam int c_byte_bits      = $clog2(c_data_bytes);
    localparam int c_off_bits       = DATA_IX_IN_LINE_BITWIDTH + c_byte_bits;
    localparam int c_tag_bits       = ADDRESS_BITWIDTH - c_off_bits - LINE_IX_BITWIDTH;
    localparam int c_lines          = 1 << LINE_IX_BITWIDTH;
    localparam int c_words          = 1 << DATA_IX_IN_LINE_BITWIDTH;
    localparam int c_words_per_beat = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
    localparam int c_burst_bits     = $clog2(RAM_BURST_DATA_COUNT);
    localparam int c_beat_bits      = (RAM_BURST_DATA_COUNT > 1) ? c_burst_bits : 1;
    localparam int c_lineaddr_bits  = ADDRESS_BITWIDTH - c_off_bits;
    localparam int c_br_hi_bits     = RAM_DEPTH_BITWIDTH - c_burst_bits;
    localparam logic [c_beat_bits-1:0] c_last_beat = c_beat_bits'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HIT      = 3'd1,
        S_WB_CMD   = 3'd2,
        S_WB_DATA  = 3'd3,
        S_FILL_CMD = 3'd4,
        S_FILL     = 3'd5
    } state_t;

    state_t                                r_state;
    logic [c_lines-1:0]                    r_valid;
    logic [c_lines-1:0]                    r_dirty;
    logic [c_tag_bits-1:0]                 r_tag [c_lines];
    logic [DATA_BITWIDTH-1:0]              r_mem [c_lines][c_words];

    logic [c_tag_bits-1:0]                 r_req_tag;
    logic [LINE_IX_BITWIDTH-1:0]           r_req_line;
    logic [DATA_IX_IN_LINE_BITWIDTH-1:0]   r_req_word;
    logic [c_data_bytes-1:0]               r_req_we;
    logic [DATA_BITWIDTH-1:0]              r_req_data;
    logic [c_beat_bits-1:0]                r_beat;

    logic [DATA_BITWIDTH-1:0]              r_data_out;
    logic                                  r_data_ready;
    logic                                  r_busy;
    logic                                  r_br_cmd;
    logic                                  r_br_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]         r_br_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]    r_br_wr_data;

    logic [31:0]                           r_stat_cache_hits;
    logic [31:0]                           r_stat_cache_misses;
    logic [31:0]                           r_stat_writebacks;

    logic [c_tag_bits-1:0]                 w_in_tag;
    logic [LINE_IX_BITWIDTH-1:0]           w_in_line;
    logic [DATA_IX_IN_LINE_BITWIDTH-1:0]   w_in_word;
    logic                                  w_hit;
    logic [DATA_BITWIDTH-1:0]              w_word;
    logic [DATA_BITWIDTH-1:0]              w_merged;
    logic [c_beat_bits-1:0]                w_wb_beat_ix;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]    w_wb_beat;
    logic [c_lineaddr_bits-1:0]            w_fill_lineaddr;
    logic [c_lineaddr_bits-1:0]            w_evict_lineaddr;
    logic [RAM_DEPTH_BITWIDTH-1:0]         w_fill_br_addr;
    logic [RAM_DEPTH_BITWIDTH-1:0]         w_evict_br_addr;
    logic                                  w_unused;

    assign w_in_tag  = address[ADDRESS_BITWIDTH-1 -: c_tag_bits];
    assign w_in_line = address[c_off_bits +: LINE_IX_BITWIDTH];
    assign w_in_word = address[c_byte_bits +: DATA_IX_IN_LINE_BITWIDTH];
    assign w_hit     = r_valid[w_in_line] && (r_tag[w_in_line] == w_in_tag);
    assign w_word    = r_mem[r_req_line][r_req_word];

    // Line bytes equal burst bytes, so the RAM word address of a line is just
    // its line address with the beat-offset bits forced to zero.
    assign w_fill_lineaddr  = {r_req_tag, r_req_line};
    assign w_evict_lineaddr = {r_tag[r_req_line], r_req_line};
    assign w_fill_br_addr   = {w_fill_lineaddr[c_br_hi_bits-1:0], {c_burst_bits{1'b0}}};
    assign w_evict_br_addr  = {w_evict_lineaddr[c_br_hi_bits-1:0], {c_burst_bits{1'b0}}};

    assign w_wb_beat_ix = (r_state == S_WB_CMD) ? '0 : r_beat;

    always_comb begin
        w_merged = w_word;
        for (int b = 0; b < c_data_bytes; b++) begin
            if (r_req_we[b]) begin
                w_merged[b*8 +: 8] = r_req_data[b*8 +: 8];
            end
        end
    end

    // Lowest-addressed word occupies the least-significant slice of a beat.
    always_comb begin
        w_wb_beat = '0;
        for (int j = 0; j < c_words_per_beat; j++) begin
            w_wb_beat[j*DATA_BITWIDTH +: DATA_BITWIDTH] =
                r_mem[r_req_line][DATA_IX_IN_LINE_BITWIDTH'(int'(w_wb_beat_ix) * c_words_per_beat + j)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= S_IDLE;
            r_valid             <= '0;
            r_dirty             <= '0;
            r_req_tag           <= '0;
            r_req_line          <= '0;
            r_req_word          <= '0;
            r_req_we            <= '0;
            r_req_data          <= '0;
            r_beat              <= '0;
            r_data_out          <= '0;
            r_data_ready        <= 1'b0;
            r_busy              <= 1'b0;
            r_br_cmd            <= 1'b0;
            r_br_cmd_en         <= 1'b0;
            r_br_addr           <= '0;
            r_br_wr_data        <= '0;
            r_stat_cache_hits   <= '0;
            r_stat_cache_misses <= '0;
            r_stat_writebacks   <= '0;
        end else begin
            r_data_ready <= 1'b0;
            r_br_cmd_en  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_req_tag  <= w_in_tag;
                        r_req_line <= w_in_line;
                        r_req_word <= w_in_word;
                        r_req_we   <= write_enable;
                        r_req_data <= data_in;
                        r_busy     <= 1'b1;
                        if (w_hit) begin
                            r_stat_cache_hits <= r_stat_cache_hits + 32'd1;
                            r_state           <= S_HIT;
                        end else begin
                            r_stat_cache_misses <= r_stat_cache_misses + 32'd1;
                            r_state <= (r_valid[w_in_line] && r_dirty[w_in_line]) ? S_WB_CMD
                                                                                   : S_FILL_CMD;
                        end
                    end
                end
                S_HIT: begin
                    r_data_out   <= w_merged;
                    r_data_ready <= 1'b1;
                    r_busy       <= 1'b0;
                    if (|r_req_we) begin
                        r_dirty[r_req_line] <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                S_WB_CMD: begin
                    if (!br_busy) begin
                        r_br_cmd     <= 1'b1;
                        r_br_cmd_en  <= 1'b1;
                        r_br_addr    <= w_evict_br_addr;
                        r_br_wr_data <= w_wb_beat;
                        r_beat       <= c_beat_bits'(1);
                        r_state      <= S_WB_DATA;
                    end
                end
                S_WB_DATA: begin
                    r_br_wr_data <= w_wb_beat;
                    if (r_beat == c_last_beat) begin
                        r_stat_writebacks   <= r_stat_writebacks + 32'd1;
                        r_dirty[r_req_line] <= 1'b0;
                        r_state             <= S_FILL_CMD;
                    end else begin
                        r_beat <= r_beat + c_beat_bits'(1);
                    end
                end
                S_FILL_CMD: begin
                    if (!br_busy) begin
                        r_br_cmd    <= 1'b0;
                        r_br_cmd_en <= 1'b1;
                        r_br_addr   <= w_fill_br_addr;
                        r_beat      <= '0;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (br_rd_data_valid) begin
                        if (r_beat == c_last_beat) begin
                            r_valid[r_req_line] <= 1'b1;
                            r_dirty[r_req_line] <= 1'b0;
                            r_state             <= S_HIT;
                        end else begin
                            r_beat <= r_beat + c_beat_bits'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line storage and tags carry no reset; validity lives in r_valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_FILL && br_rd_data_valid) begin
                for (int j = 0; j < c_words_per_beat; j++) begin
                    r_mem[r_req_line][DATA_IX_IN_LINE_BITWIDTH'(int'(r_beat) * c_words_per_beat + j)]
                        <= br_rd_data[j*DATA_BITWIDTH +: DATA_BITWIDTH];
                end
                if (r_beat == c_last_beat) begin
                    r_tag[r_req_line] <= r_req_tag;
                end
            end
            if (r_state == S_HIT && |r_req_we) begin
                r_mem[r_req_line][r_req_word] <= w_merged;
            end
        end
    end

    assign data_out     = r_data_out;
    assign data_ready   = r_data_ready;
    assign busy         = r_busy;
    assign br_cmd       = r_br_cmd;
    assign br_cmd_en    = r_br_cmd_en;
    assign br_addr      = r_br_addr;
    assign br_wr_data   = r_br_wr_data;
    assign br_data_mask = '0;

    assign w_unused = ^{address[c_byte_bits-1:0], w_fill_lineaddr, w_evict_lineaddr,
                        r_stat_cache_hits, r_stat_cache_misses, r_stat_writebacks};

endmodule

`default_nettype wire

// File: tb/tb_cache_data.sv
//==============================================================================
// Module      : tb_cache_data
// Description : Directed self-checking bench for cache_data with a BurstRAM model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cache_data;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] address;
    logic [3:0]  write_enable;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_ready;
    logic        busy;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        br_busy;

    cache_data #(
        .LINE_IX_BITWIDTH        (1),
        .ADDRESS_BITWIDTH        (32),
        .DATA_BITWIDTH           (32),
        .DATA_IX_IN_LINE_BITWIDTH(3),
        .RAM_DEPTH_BITWIDTH      (4),
        .RAM_BURST_DATA_BITWIDTH (64),
        .RAM_BURST_DATA_COUNT    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .address         (address),
        .write_enable    (write_enable),
        .data_in         (data_in),
        .data_out        (data_out),
        .data_ready      (data_ready),
        .busy            (busy),
        .br_cmd          (br_cmd),
        .br_cmd_en       (br_cmd_en),
        .br_addr         (br_addr),
        .br_wr_data      (br_wr_data),
        .br_data_mask    (br_data_mask),
        .br_rd_data      (br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .br_busy         (br_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // BurstRAM model state
    logic [63:0] ram [16];
    int          rm_state = 0;   // 0 idle, 1 write beats, 2 read beats, 3 trailing busy
    int          rm_cnt   = 0;
    int          rm_delay = 0;
    bit          rm_gap_done;
    logic [3:0]  rm_base;
    int          rd_cmds = 0;
    int          wr_cmds = 0;
    int          cmd_while_busy = 0;
    logic [3:0]  last_rd_addr = '0;
    logic [3:0]  last_wr_addr = '0;
    logic [63:0] wb_beat0 = '0;
    logic [7:0]  wb_mask  = '1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder for the BurstRAM side: reacts on the falling edge, away from the DUT's edge.
    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i] = {32'hA000_0000 + 32'(2*i + 1), 32'hA000_0000 + 32'(2*i)};
        end
        ram[0]        = {32'h3F5A2E14, 32'hB7C6A980};
        ram[4][31:0]  = 32'h2F5E3C7A;
        ram[8][63:32] = 32'h0A1B2C3D;
        br_busy          = 1'b0;
        br_rd_data_valid = 1'b0;
        br_rd_data       = '0;
        rm_base          = '0;
        rm_gap_done      = 1'b0;
        forever begin
            @(negedge clk);
            br_rd_data_valid = 1'b0;
            if (br_cmd_en) begin
                if (br_busy) cmd_while_busy++;
                rm_base = br_addr;
                br_busy = 1'b1;
                if (br_cmd) begin
                    wr_cmds++;
                    last_wr_addr = br_addr;
                    wb_beat0     = br_wr_data;
                    wb_mask      = br_data_mask;
                    ram[rm_base] = br_wr_data;
                    rm_cnt       = 1;
                    rm_state     = 1;
                end else begin
                    rd_cmds++;
                    last_rd_addr = br_addr;
                    rm_cnt       = 0;
                    rm_delay     = 2;
                    rm_gap_done  = 1'b0;
                    rm_state     = 2;
                end
            end else begin
                case (rm_state)
                    1: begin
                        ram[rm_base + 4'(rm_cnt)] = br_wr_data;
                        rm_cnt++;
                        if (rm_cnt == 4) begin
                            rm_state = 3;
                            rm_delay = 2;
                        end
                    end
                    2: begin
                        if (rm_delay > 0) begin
                            rm_delay--;
                        end else begin
                            br_rd_data       = ram[rm_base + 4'(rm_cnt)];
                            br_rd_data_valid = 1'b1;
                            rm_cnt++;
                            if (rm_cnt == 2 && !rm_gap_done) begin
                                rm_gap_done = 1'b1;
                                rm_delay    = 1;
                            end
                            if (rm_cnt == 4) begin
                                rm_state = 3;
                                rm_delay = 1;
                            end
                        end
                    end
                    3: begin
                        if (rm_delay > 0) begin
                            rm_delay--;
                        end else begin
                            rm_state = 0;
                            br_busy  = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Issue one request and wait (bounded) for its data_ready pulse.
    task automatic req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                       output logic [31:0] q, output int lat);
        bit got;
        @(posedge clk); #1;
        enable = 1'b1; address = a; write_enable = we; data_in = d;
        @(posedge clk); #1;
        enable = 1'b0;
        q   = 'x;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (data_ready) begin
                q   = data_out;
                got = 1'b1;
            end
        end
        chk("req_done", 64'(got), 64'd1);
    endtask

    logic [31:0] q;
    int          lat;
    int          s_rd;
    int          s_wr;
    bit          got;

    initial begin
        rst = 1'b1; enable = 1'b0; address = '0; write_enable = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_ready",      64'(data_ready), 64'd0);
        chk("rst_cmd_en",     64'(br_cmd_en),  64'd0);
        chk("rst_cmd",        64'(br_cmd),     64'd0);
        chk("rst_data_out",   64'(data_out),   64'd0);
        chk("rst_valid",      64'(dut.r_valid), 64'd0);

        // 1: cold read miss
        s_rd = rd_cmds; s_wr = wr_cmds;
        req(32'd0, 4'b0000, 32'd0, q, lat);
        chk("s1_data",     64'(q), 64'hB7C6A980);
        chk("s1_misses",   64'(dut.r_stat_cache_misses), 64'd1);
        chk("s1_hits",     64'(dut.r_stat_cache_hits),   64'd0);
        chk("s1_rd_burst", 64'(rd_cmds - s_rd), 64'd1);
        chk("s1_rd_addr",  64'(last_rd_addr), 64'd0);
        chk("s1_wr_burst", 64'(wr_cmds - s_wr), 64'd0);

        // 2: read hit latency and pulse width
        s_rd = rd_cmds; s_wr = wr_cmds;
        req(32'd4, 4'b0000, 32'd0, q, lat);
        chk("s2_data",    64'(q), 64'h3F5A2E14);
        chk("s2_latency", 64'(lat), 64'd2);
        chk("s2_hits",    64'(dut.r_stat_cache_hits), 64'd1);
        chk("s2_traffic", 64'((rd_cmds - s_rd) + (wr_cmds - s_wr)), 64'd0);
        @(negedge clk);
        chk("s2_pulse",   64'(data_ready), 64'd0);
        chk("s2_idle",    64'(busy), 64'd0);

        // 3: byte-masked write hit then read back
        s_rd = rd_cmds; s_wr = wr_cmds;
        req(32'd4, 4'b0011, 32'h0000BEEF, q, lat);
        chk("s3_wr_data", 64'(q), 64'h3F5ABEEF);
        chk("s3_dirty",   64'(dut.r_dirty), 64'd1);
        req(32'd4, 4'b0000, 32'd0, q, lat);
        chk("s3_rd_data", 64'(q), 64'h3F5ABEEF);
        chk("s3_hits",    64'(dut.r_stat_cache_hits), 64'd3);
        chk("s3_traffic", 64'((rd_cmds - s_rd) + (wr_cmds - s_wr)), 64'd0);

        // 4: conflict miss on a dirty line
        s_rd = rd_cmds; s_wr = wr_cmds;
        req(32'd64, 4'b0000, 32'd0, q, lat);
        chk("s4_wr_burst", 64'(wr_cmds - s_wr), 64'd1);
        chk("s4_wr_addr",  64'(last_wr_addr), 64'd0);
        chk("s4_beat0",    wb_beat0, {32'h3F5ABEEF, 32'hB7C6A980});
        chk("s4_mask",     64'(wb_mask), 64'd0);
        chk("s4_ram1",     ram[1], {32'hA0000003, 32'hA0000002});
        chk("s4_ram3",     ram[3], {32'hA0000007, 32'hA0000006});
        chk("s4_rd_burst", 64'(rd_cmds - s_rd), 64'd1);
        chk("s4_rd_addr",  64'(last_rd_addr), 64'd8);
        chk("s4_data",     64'(q), 64'hA0000010);
        chk("s4_wbs",      64'(dut.r_stat_writebacks),   64'd1);
        chk("s4_misses",   64'(dut.r_stat_cache_misses), 64'd2);
        chk("s4_dirty",    64'(dut.r_dirty), 64'd0);
        req(32'd68, 4'b0000, 32'd0, q, lat);
        chk("s4_hi_word",  64'(q), 64'h0A1B2C3D);
        chk("s4_hits",     64'(dut.r_stat_cache_hits), 64'd4);

        // 5: clean eviction, refill shows written-back data
        s_rd = rd_cmds; s_wr = wr_cmds;
        req(32'd4, 4'b0000, 32'd0, q, lat);
        chk("s5_data",     64'(q), 64'h3F5ABEEF);
        chk("s5_wr_burst", 64'(wr_cmds - s_wr), 64'd0);
        chk("s5_rd_burst", 64'(rd_cmds - s_rd), 64'd1);
        chk("s5_rd_addr",  64'(last_rd_addr), 64'd0);
        chk("s5_misses",   64'(dut.r_stat_cache_misses), 64'd3);

        // 6: reset in the middle of a fill
        @(posedge clk); #1;
        enable = 1'b1; address = 32'd32; write_enable = 4'b0000;
        @(posedge clk); #1;
        enable = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (rm_state == 2 && rm_cnt >= 2) got = 1'b1;
        end
        chk("s6_in_fill", 64'(got), 64'd1);
        chk("s6_busy_pre", 64'(busy), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("s6_busy",   64'(busy), 64'd0);
        chk("s6_ready",  64'(data_ready), 64'd0);
        chk("s6_valid",  64'(dut.r_valid), 64'd0);
        chk("s6_hits0",  64'(dut.r_stat_cache_hits), 64'd0);
        chk("s6_miss0",  64'(dut.r_stat_cache_misses), 64'd0);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (rm_state == 0) got = 1'b1;
        end
        chk("s6_ram_idle",  64'(got), 64'd1);
        chk("s6_late_beats", 64'(dut.r_valid), 64'd0);
        chk("s6_busy_late", 64'(busy), 64'd0);
        s_rd = rd_cmds;
        req(32'd32, 4'b0000, 32'd0, q, lat);
        chk("s6_data",     64'(q), 64'h2F5E3C7A);
        chk("s6_misses",   64'(dut.r_stat_cache_misses), 64'd1);
        chk("s6_wbs",      64'(dut.r_stat_writebacks), 64'd0);
        chk("s6_rd_burst", 64'(rd_cmds - s_rd), 64'd1);
        chk("s6_rd_addr",  64'(last_rd_addr), 64'd4);

        chk("cmd_while_busy", 64'(cmd_while_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cache_data.md
Name: cache_data

Overview:
- Direct-mapped, write-back data cache for the RISC-V core's load/store path.
- Parametrised successor to the instruction cache: adds byte-masked writes, per-line dirty bits and burst write-back of evicted lines.
- Sits between the core and the BurstRAM controller (`br_` ports).
- One clock; reset is synchronous and active-high.

Parameters:
- LINE_IX_BITWIDTH, 1, log2 of number of cache lines.
- ADDRESS_BITWIDTH, 32, byte address width.
- DATA_BITWIDTH, 32, word width, multiple of 8.
- DATA_IX_IN_LINE_BITWIDTH, 3, log2 of words per line.
- RAM_DEPTH_BITWIDTH, 4, BurstRAM address width, in RAM words.
- RAM_BURST_DATA_BITWIDTH, 64, BurstRAM word width.
- RAM_BURST_DATA_COUNT, 4, beats per burst. Line bytes must equal burst bytes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  request strobe, sampled when busy=0
- address  in  ADDRESS_BITWIDTH  byte address, word aligned
- write_enable  in  DATA_BITWIDTH/8  byte write mask; 0 = read
- data_in  in  DATA_BITWIDTH  store data
- data_out  out  DATA_BITWIDTH  load data, valid while data_ready
- data_ready  out  1  one-cycle pulse, request completed
- busy  out  1  request in progress
- br_cmd  out  1  0 = read, 1 = write
- br_cmd_en  out  1  one-cycle command strobe
- br_addr  out  RAM_DEPTH_BITWIDTH  first RAM word of the line
- br_wr_data  out  RAM_BURST_DATA_BITWIDTH  write beat
- br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8  1 = byte not written; always 0
- br_rd_data  in  RAM_BURST_DATA_BITWIDTH  read beat
- br_rd_data_valid  in  1  read beat valid
- br_busy  in  1  RAM not ready for a command

Behaviour:
- Address split: word offset = bits [DATA_IX+log2(DATA_BYTES)-1 : log2(DATA_BYTES)], then line index, then tag (remaining bits).
- br_addr = address >> log2(RAM_BURST_DATA_BITWIDTH/8), with the low log2(RAM_BURST_DATA_COUNT) bits zeroed.
- Reset: all valid and dirty bits cleared; state IDLE; busy=0, data_ready=0, br_cmd_en=0, br_cmd=0, data_out=0; stat_cache_hits, stat_cache_misses and stat_writebacks (internal 32-bit regs) cleared.
- Reset mid-operation abandons any burst. Late br_rd_data_valid beats after reset are ignored.
- IDLE: on enable, latch address, write_enable and data_in; busy=1 from the next cycle.
  - Hit (valid and tag match) -> HIT. Increment hits.
  - Otherwise increment misses. Go to WB_CMD if the line is valid and dirty, else FILL_CMD.
- HIT, one cycle:
  - Read: data_out = word; data_ready=1.
  - Write: bytes with write_enable=1 are merged; dirty set; data_ready=1; data_out = merged word.
  - Next state IDLE, busy=0 in the same cycle, so a new request can be accepted on the following edge.
  - Hit latency: enable edge N -> data_ready during cycle N+1.
- WB_CMD: wait for !br_busy, then br_cmd=1, br_cmd_en=1 with the evicted line's address (stored tag). Beat 0 goes on br_wr_data in the same cycle. Go to WB_DATA.
- WB_DATA: beats 1..RAM_BURST_DATA_COUNT-1 on consecutive cycles. Increment stat_writebacks, clear dirty, go to FILL_CMD.
- FILL_CMD: wait for !br_busy, then br_cmd=0, br_cmd_en=1. Go to FILL.
- FILL: each br_rd_data_valid beat is written into the line at the beat counter, lowest RAM word first (little-endian within a beat). After the last beat: set tag and valid, dirty=0, go to HIT. The pending request then completes exactly as a hit, but without a second hit count.
- enable while busy=1 is ignored.
- br_cmd_en is never asserted while br_busy=1.
- Write miss is write-allocate.

Test Plan:
Bench config: LINE_IX_BITWIDTH=1, 32-bit words, 8 words/line, 64-bit RAM words, bursts of 4. RAM.mem word0[31:0]=B7C6A980, word0[63:32]=3F5A2E14, address 32 holds 2F5E3C7A, address 68 holds 0A1B2C3D.

1. Read 0 after reset -> misses=1, data_out=B7C6A980, one read burst at br_addr=0, no write burst.
2. Read 4 -> hits=1, data_out=3F5A2E14, data_ready one cycle after enable, no br_cmd_en.
3. Write 4, write_enable=0011, data_in=0000BEEF, then read 4 -> data_out=3F5ABEEF, hits=3, no RAM traffic.
4. Read 64 (same line index as 0, dirty) -> write burst first at br_addr=0, with beat0[63:32]=3F5ABEEF and data_mask=0. Then read burst at br_addr=8. stat_writebacks=1, misses=2.
5. Read 4 again -> miss and refill from RAM: data_out=3F5ABEEF, proving write-back. Line clean, so no write burst.
6. Assert rst during FILL of a read of 32, then read 32 -> busy=0 one cycle after reset, valid bits clear, then a fresh miss with data_out=2F5E3C7A.
